// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, block constants,
// GF(2^8) helpers and the round-key slice helper.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NB       = 4;
    localparam int BLK_W    = 128;
    localparam int MAX_RK_W = 15 * BLK_W;

    typedef logic [MAX_RK_W-1:0] rk_vec_t;

    // Multiply by x in GF(2^8) modulo 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; byte 0 (row 0) is in the MSBs.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Round r key; round 0 sits in the MSBs of an (nr+1)*128 vector.
    function automatic logic [BLK_W-1:0] rk_slice(
        input rk_vec_t    keys,
        input logic [3:0] r,
        input logic [3:0] nr
    );
        int base;
        base = BLK_W * (int'(nr) - int'(r));
        return keys[base +: BLK_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational.
// One instance per state byte.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Table lookup of the SubBytes substitution.
    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h63; 8'h01: o_byte = 8'h7c; 8'h02: o_byte = 8'h77; 8'h03: o_byte = 8'h7b;
            8'h04: o_byte = 8'hf2; 8'h05: o_byte = 8'h6b; 8'h06: o_byte = 8'h6f; 8'h07: o_byte = 8'hc5;
            8'h08: o_byte = 8'h30; 8'h09: o_byte = 8'h01; 8'h0a: o_byte = 8'h67; 8'h0b: o_byte = 8'h2b;
            8'h0c: o_byte = 8'hfe; 8'h0d: o_byte = 8'hd7; 8'h0e: o_byte = 8'hab; 8'h0f: o_byte = 8'h76;
            8'h10: o_byte = 8'hca; 8'h11: o_byte = 8'h82; 8'h12: o_byte = 8'hc9; 8'h13: o_byte = 8'h7d;
            8'h14: o_byte = 8'hfa; 8'h15: o_byte = 8'h59; 8'h16: o_byte = 8'h47; 8'h17: o_byte = 8'hf0;
            8'h18: o_byte = 8'had; 8'h19: o_byte = 8'hd4; 8'h1a: o_byte = 8'ha2; 8'h1b: o_byte = 8'haf;
            8'h1c: o_byte = 8'h9c; 8'h1d: o_byte = 8'ha4; 8'h1e: o_byte = 8'h72; 8'h1f: o_byte = 8'hc0;
            8'h20: o_byte = 8'hb7; 8'h21: o_byte = 8'hfd; 8'h22: o_byte = 8'h93; 8'h23: o_byte = 8'h26;
            8'h24: o_byte = 8'h36; 8'h25: o_byte = 8'h3f; 8'h26: o_byte = 8'hf7; 8'h27: o_byte = 8'hcc;
            8'h28: o_byte = 8'h34; 8'h29: o_byte = 8'ha5; 8'h2a: o_byte = 8'he5; 8'h2b: o_byte = 8'hf1;
            8'h2c: o_byte = 8'h71; 8'h2d: o_byte = 8'hd8; 8'h2e: o_byte = 8'h31; 8'h2f: o_byte = 8'h15;
            8'h30: o_byte = 8'h04; 8'h31: o_byte = 8'hc7; 8'h32: o_byte = 8'h23; 8'h33: o_byte = 8'hc3;
            8'h34: o_byte = 8'h18; 8'h35: o_byte = 8'h96; 8'h36: o_byte = 8'h05; 8'h37: o_byte = 8'h9a;
            8'h38: o_byte = 8'h07; 8'h39: o_byte = 8'h12; 8'h3a: o_byte = 8'h80; 8'h3b: o_byte = 8'he2;
            8'h3c: o_byte = 8'heb; 8'h3d: o_byte = 8'h27; 8'h3e: o_byte = 8'hb2; 8'h3f: o_byte = 8'h75;
            8'h40: o_byte = 8'h09; 8'h41: o_byte = 8'h83; 8'h42: o_byte = 8'h2c; 8'h43: o_byte = 8'h1a;
            8'h44: o_byte = 8'h1b; 8'h45: o_byte = 8'h6e; 8'h46: o_byte = 8'h5a; 8'h47: o_byte = 8'ha0;
            8'h48: o_byte = 8'h52; 8'h49: o_byte = 8'h3b; 8'h4a: o_byte = 8'hd6; 8'h4b: o_byte = 8'hb3;
            8'h4c: o_byte = 8'h29; 8'h4d: o_byte = 8'he3; 8'h4e: o_byte = 8'h2f; 8'h4f: o_byte = 8'h84;
            8'h50: o_byte = 8'h53; 8'h51: o_byte = 8'hd1; 8'h52: o_byte = 8'h00; 8'h53: o_byte = 8'hed;
            8'h54: o_byte = 8'h20; 8'h55: o_byte = 8'hfc; 8'h56: o_byte = 8'hb1; 8'h57: o_byte = 8'h5b;
            8'h58: o_byte = 8'h6a; 8'h59: o_byte = 8'hcb; 8'h5a: o_byte = 8'hbe; 8'h5b: o_byte = 8'h39;
            8'h5c: o_byte = 8'h4a; 8'h5d: o_byte = 8'h4c; 8'h5e: o_byte = 8'h58; 8'h5f: o_byte = 8'hcf;
            8'h60: o_byte = 8'hd0; 8'h61: o_byte = 8'hef; 8'h62: o_byte = 8'haa; 8'h63: o_byte = 8'hfb;
            8'h64: o_byte = 8'h43; 8'h65: o_byte = 8'h4d; 8'h66: o_byte = 8'h33; 8'h67: o_byte = 8'h85;
            8'h68: o_byte = 8'h45; 8'h69: o_byte = 8'hf9; 8'h6a: o_byte = 8'h02; 8'h6b: o_byte = 8'h7f;
            8'h6c: o_byte = 8'h50; 8'h6d: o_byte = 8'h3c; 8'h6e: o_byte = 8'h9f; 8'h6f: o_byte = 8'ha8;
            8'h70: o_byte = 8'h51; 8'h71: o_byte = 8'ha3; 8'h72: o_byte = 8'h40; 8'h73: o_byte = 8'h8f;
            8'h74: o_byte = 8'h92; 8'h75: o_byte = 8'h9d; 8'h76: o_byte = 8'h38; 8'h77: o_byte = 8'hf5;
            8'h78: o_byte = 8'hbc; 8'h79: o_byte = 8'hb6; 8'h7a: o_byte = 8'hda; 8'h7b: o_byte = 8'h21;
            8'h7c: o_byte = 8'h10; 8'h7d: o_byte = 8'hff; 8'h7e: o_byte = 8'hf3; 8'h7f: o_byte = 8'hd2;
            8'h80: o_byte = 8'hcd; 8'h81: o_byte = 8'h0c; 8'h82: o_byte = 8'h13; 8'h83: o_byte = 8'hec;
            8'h84: o_byte = 8'h5f; 8'h85: o_byte = 8'h97; 8'h86: o_byte = 8'h44; 8'h87: o_byte = 8'h17;
            8'h88: o_byte = 8'hc4; 8'h89: o_byte = 8'ha7; 8'h8a: o_byte = 8'h7e; 8'h8b: o_byte = 8'h3d;
            8'h8c: o_byte = 8'h64; 8'h8d: o_byte = 8'h5d; 8'h8e: o_byte = 8'h19; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h60; 8'h91: o_byte = 8'h81; 8'h92: o_byte = 8'h4f; 8'h93: o_byte = 8'hdc;
            8'h94: o_byte = 8'h22; 8'h95: o_byte = 8'h2a; 8'h96: o_byte = 8'h90; 8'h97: o_byte = 8'h88;
            8'h98: o_byte = 8'h46; 8'h99: o_byte = 8'hee; 8'h9a: o_byte = 8'hb8; 8'h9b: o_byte = 8'h14;
            8'h9c: o_byte = 8'hde; 8'h9d: o_byte = 8'h5e; 8'h9e: o_byte = 8'h0b; 8'h9f: o_byte = 8'hdb;
            8'ha0: o_byte = 8'he0; 8'ha1: o_byte = 8'h32; 8'ha2: o_byte = 8'h3a; 8'ha3: o_byte = 8'h0a;
            8'ha4: o_byte = 8'h49; 8'ha5: o_byte = 8'h06; 8'ha6: o_byte = 8'h24; 8'ha7: o_byte = 8'h5c;
            8'ha8: o_byte = 8'hc2; 8'ha9: o_byte = 8'hd3; 8'haa: o_byte = 8'hac; 8'hab: o_byte = 8'h62;
            8'hac: o_byte = 8'h91; 8'had: o_byte = 8'h95; 8'hae: o_byte = 8'he4; 8'haf: o_byte = 8'h79;
            8'hb0: o_byte = 8'he7; 8'hb1: o_byte = 8'hc8; 8'hb2: o_byte = 8'h37; 8'hb3: o_byte = 8'h6d;
            8'hb4: o_byte = 8'h8d; 8'hb5: o_byte = 8'hd5; 8'hb6: o_byte = 8'h4e; 8'hb7: o_byte = 8'ha9;
            8'hb8: o_byte = 8'h6c; 8'hb9: o_byte = 8'h56; 8'hba: o_byte = 8'hf4; 8'hbb: o_byte = 8'hea;
            8'hbc: o_byte = 8'h65; 8'hbd: o_byte = 8'h7a; 8'hbe: o_byte = 8'hae; 8'hbf: o_byte = 8'h08;
            8'hc0: o_byte = 8'hba; 8'hc1: o_byte = 8'h78; 8'hc2: o_byte = 8'h25; 8'hc3: o_byte = 8'h2e;
            8'hc4: o_byte = 8'h1c; 8'hc5: o_byte = 8'ha6; 8'hc6: o_byte = 8'hb4; 8'hc7: o_byte = 8'hc6;
            8'hc8: o_byte = 8'he8; 8'hc9: o_byte = 8'hdd; 8'hca: o_byte = 8'h74; 8'hcb: o_byte = 8'h1f;
            8'hcc: o_byte = 8'h4b; 8'hcd: o_byte = 8'hbd; 8'hce: o_byte = 8'h8b; 8'hcf: o_byte = 8'h8a;
            8'hd0: o_byte = 8'h70; 8'hd1: o_byte = 8'h3e; 8'hd2: o_byte = 8'hb5; 8'hd3: o_byte = 8'h66;
            8'hd4: o_byte = 8'h48; 8'hd5: o_byte = 8'h03; 8'hd6: o_byte = 8'hf6; 8'hd7: o_byte = 8'h0e;
            8'hd8: o_byte = 8'h61; 8'hd9: o_byte = 8'h35; 8'hda: o_byte = 8'h57; 8'hdb: o_byte = 8'hb9;
            8'hdc: o_byte = 8'h86; 8'hdd: o_byte = 8'hc1; 8'hde: o_byte = 8'h1d; 8'hdf: o_byte = 8'h9e;
            8'he0: o_byte = 8'he1; 8'he1: o_byte = 8'hf8; 8'he2: o_byte = 8'h98; 8'he3: o_byte = 8'h11;
            8'he4: o_byte = 8'h69; 8'he5: o_byte = 8'hd9; 8'he6: o_byte = 8'h8e; 8'he7: o_byte = 8'h94;
            8'he8: o_byte = 8'h9b; 8'he9: o_byte = 8'h1e; 8'hea: o_byte = 8'h87; 8'heb: o_byte = 8'he9;
            8'hec: o_byte = 8'hce; 8'hed: o_byte = 8'h55; 8'hee: o_byte = 8'h28; 8'hef: o_byte = 8'hdf;
            8'hf0: o_byte = 8'h8c; 8'hf1: o_byte = 8'ha1; 8'hf2: o_byte = 8'h89; 8'hf3: o_byte = 8'h0d;
            8'hf4: o_byte = 8'hbf; 8'hf5: o_byte = 8'he6; 8'hf6: o_byte = 8'h42; 8'hf7: o_byte = 8'h68;
            8'hf8: o_byte = 8'h41; 8'hf9: o_byte = 8'h99; 8'hfa: o_byte = 8'h2d; 8'hfb: o_byte = 8'h0f;
            8'hfc: o_byte = 8'hb0; 8'hfd: o_byte = 8'h54; 8'hfe: o_byte = 8'hbb; 8'hff: o_byte = 8'h16;
        endcase
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one full round per clock,
// round keys supplied flattened by the upstream key schedule.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BLK_W-1:0]        plaintext,
    input  logic [(Nr+1)*BLK_W-1:0] round_keys,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BLK_W-1:0]        ciphertext,
    output logic                    busy
);

    if ((Nr != Nk + 6) || ((Nk != 4) && (Nk != 6) && (Nk != 8))) begin : g_bad_cfg
        $error("aes_cipher_iter: illegal Nk/Nr combination");
    end

    localparam logic [3:0] NR_L = 4'(Nr);

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_round;
    logic [BLK_W-1:0] r_data;
    rk_vec_t          w_keys;
    logic [BLK_W-1:0] w_rk0;
    logic [BLK_W-1:0] w_rk;
    logic [BLK_W-1:0] w_sb;
    logic [BLK_W-1:0] w_sr;
    logic [BLK_W-1:0] w_mc;
    logic [BLK_W-1:0] w_rnd;

    assign w_keys = rk_vec_t'(round_keys);
    assign w_rk0  = rk_slice(w_keys, 4'd0, NR_L);
    assign w_rk   = rk_slice(w_keys, r_round, NR_L);

    for (genvar i = 0; i < 4 * NB; i++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_data[BLK_W-1-8*i -: 8]),
            .o_byte (w_sb[BLK_W-1-8*i -: 8])
        );
    end

    // ShiftRows: row r rotates left by r columns.
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[BLK_W-1-8*(r+4*c) -: 8] =
                    w_sb[BLK_W-1-8*(r+4*((c+r)%NB)) -: 8];
            end
        end
    end

    // MixColumns per column, bypassed in the final round, then AddRoundKey.
    always_comb begin
        w_mc = '0;
        for (int c = 0; c < NB; c++) begin
            w_mc[BLK_W-1-32*c -: 32] = mix_col(w_sr[BLK_W-1-32*c -: 32]);
        end
        w_rnd = ((r_round == NR_L) ? w_sr : w_mc) ^ w_rk;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (in_valid)        w_next = ST_ROUND;
            ST_ROUND: if (r_round == NR_L) w_next = ST_DONE;
            ST_DONE:  if (out_ready)       w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    // Datapath: load whitened block on accept, apply one round per ROUND cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_round <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_data  <= plaintext ^ w_rk0;
                        r_round <= 4'd1;
                    end
                end
                ST_ROUND: begin
                    r_data <= w_rnd;
                    if (r_round != NR_L) r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign out_valid  = (r_state == ST_DONE);
    assign ciphertext = out_valid ? r_data : '0;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors for all
// three key sizes, backpressure, back-to-back and mid-run reset.
module tb_aes_cipher_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   iv = '0;
    logic [2:0]   ordy = '1;
    logic [127:0] pt = '0;
    logic [1407:0] rk0 = '0;
    logic [1663:0] rk1 = '0;
    logic [1919:0] rk2 = '0;
    wire  [2:0]   ir, ov, bz;
    wire  [127:0] ct0, ct1, ct2;
    int           checks = 0;
    int           fails = 0;
    int           cyc = 0;

    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [191:0] K_C2  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_cipher_iter #(.Nk(4), .Nr(10)) u_dut128 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .plaintext(pt), .round_keys(rk0), .out_valid(ov[0]),
        .out_ready(ordy[0]), .ciphertext(ct0), .busy(bz[0])
    );
    aes_cipher_iter #(.Nk(6), .Nr(12)) u_dut192 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .plaintext(pt), .round_keys(rk1), .out_valid(ov[1]),
        .out_ready(ordy[1]), .ciphertext(ct1), .busy(bz[1])
    );
    aes_cipher_iter #(.Nk(8), .Nr(14)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .plaintext(pt), .round_keys(rk2), .out_valid(ov[2]),
        .out_ready(ordy[2]), .ciphertext(ct2), .busy(bz[2])
    );

    // Reference GF(2^8) arithmetic and S-box (inverse + affine map).
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [7:0] y, s;
        y = 8'h01;
        for (int i = 0; i < 254; i++) y = gmul(y, x);
        s = y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
              ^ {y[3:0], y[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    // Reference key schedule; key left-aligned in 256 bits.
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] r;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < 4 * (nr + 1); i++)
            r[(nr+1)*128-1-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] cto(input int d);
        return (d == 0) ? ct0 : (d == 1) ? ct1 : ct2;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one block, measure latency, check result and handshake.
    task automatic run_block(input int d, input logic [127:0] p,
                             input logic [127:0] exp, input int nr,
                             input string tag);
        int n, lat, hi;
        pt      = p;
        ordy[d] = 1'b1;
        iv[d]   = 1'b1;
        n = 0;
        while (!ir[d] && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_rdy"}, 128'(ir[d]), 128'd1);
        tick();
        iv[d] = 1'b0;
        lat = 0;
        hi  = 0;
        while (!ov[d] && lat < 40) begin
            if (ir[d]) hi++;
            tick();
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(nr));
        chk({tag, "_irlo"}, 128'(hi), 128'd0);
        chk({tag, "_ct"}, cto(d), exp);
        tick();
        chk({tag, "_irhi"}, 128'(ir[d]), 128'd1);
        chk({tag, "_ovlo"}, 128'(ov[d]), 128'd0);
    endtask

    logic [1919:0] tmp;
    int            t0, t1, lat, hi;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ir", 128'(ir[0]), 128'd1);
        chk("rst_ov", 128'(ov[0]), 128'd0);
        chk("rst_bz", 128'(bz[0]), 128'd0);
        chk("rst_ct", ct0, 128'd0);

        tmp = expand({K_B, 128'h0}, 4);
        rk0 = tmp[1407:0];
        run_block(0, PT_B, CT_B, 10, "b128");

        tmp = expand({K_C2, 64'h0}, 6);
        rk1 = tmp[1663:0];
        run_block(1, PT_C, CT_C2, 12, "c192");

        tmp = expand(K_C3, 8);
        rk2 = tmp;
        run_block(2, PT_C, CT_C3, 14, "c256");

        // Backpressure with in_valid pulses while DONE.
        tmp = expand({K_C1, 128'h0}, 4);
        rk0 = tmp[1407:0];
        pt = PT_C;
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 40) begin
            tick();
            lat++;
        end
        chk("bp_lat", 128'(lat), 128'd10);
        for (int k = 0; k < 5; k++) begin
            iv[0] = (k % 2 == 0);
            tick();
            chk("bp_ct", ct0, CT_C1);
            chk("bp_ov", 128'(ov[0]), 128'd1);
            chk("bp_ir", 128'(ir[0]), 128'd0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        tick();
        chk("bp_rel_ov", 128'(ov[0]), 128'd0);
        chk("bp_rel_ir", 128'(ir[0]), 128'd1);

        // Back-to-back: App. B then App. C.1 with in_valid held high.
        tmp = expand({K_B, 128'h0}, 4);
        rk0 = tmp[1407:0];
        pt = PT_B;
        iv[0] = 1'b1;
        tick();
        t0 = cyc;
        lat = 0;
        hi = 0;
        while (!ov[0] && lat < 40) begin
            if (ir[0]) hi++;
            tick();
            lat++;
        end
        chk("b2b_lat0", 128'(lat), 128'd10);
        chk("b2b_ct0", ct0, CT_B);
        tmp = expand({K_C1, 128'h0}, 4);
        rk0 = tmp[1407:0];
        pt = PT_C;
        tick();
        chk("b2b_ir", 128'(ir[0]), 128'd1);
        tick();
        t1 = cyc;
        iv[0] = 1'b0;
        chk("b2b_gap", 128'(t1 - t0), 128'd12);
        lat = 0;
        while (!ov[0] && lat < 40) begin
            if (ir[0]) hi++;
            tick();
            lat++;
        end
        chk("b2b_lat1", 128'(lat), 128'd10);
        chk("b2b_irlo", 128'(hi), 128'd0);
        chk("b2b_ct1", ct0, CT_C1);
        tick();

        // Reset while round 5 is in progress.
        pt = PT_C;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        chk("mid_bz", 128'(bz[0]), 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_ov", 128'(ov[0]), 128'd0);
        chk("mid_bz0", 128'(bz[0]), 128'd0);
        chk("mid_ir", 128'(ir[0]), 128'd1);
        chk("mid_ct", ct0, 128'd0);
        tmp = expand({K_B, 128'h0}, 4);
        rk0 = tmp[1407:0];
        run_block(0, PT_B, CT_B, 10, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/aes_cipher_iter.md
# aes_cipher_iter

Iterative AES encryption core that consumes the flattened round-key vector produced by `keyExpansion` and one 128-bit plaintext block. It applies one full AES round per clock and presents the ciphertext on a valid/ready output. The core sits directly downstream of the key schedule and is parameterized identically, with Nk and Nr, for AES-128, AES-192 and AES-256.

## Interface
- `Nk`, 4, key length in 32-bit words; legal values 4, 6, 8.
- `Nr`, 10, number of rounds; must equal Nk+6, otherwise the design is rejected at elaboration.

Ports:
- `clk`, input, 1, the single clock; all state changes on the rising edge.
- `rst`, input, 1, synchronous active-high reset.
- `in_valid`, input, 1, plaintext and round keys are valid.
- `in_ready`, output, 1, core can accept a block; high only in IDLE.
- `plaintext`, input, 128, block in FIPS-197 byte order; byte 0 is [127:120]; column-major state.
- `round_keys`, input, (Nr+1)*128, expanded key; round r key = `round_keys[(Nr+1)*128-1-128*r -: 128]`, with round 0 in the MSBs.
- `out_valid`, output, 1, ciphertext is valid.
- `out_ready`, input, 1, downstream accepts the ciphertext.
- `ciphertext`, output, 128, result in the same byte order as plaintext.
- `busy`, output, 1, high in ROUND or DONE.

## Operation
- FSM states are IDLE, ROUND and DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, the state register is loaded with plaintext ^ rk[0], the round counter is set to 1, and the FSM goes to ROUND.
- ROUND:
  - Each cycle computes SubBytes, then ShiftRows, then MixColumns, then AddRoundKey with rk[round].
  - MixColumns is bypassed when round == Nr.
  - The counter increments each cycle; after round Nr the FSM goes to DONE.
- DONE:
  - `out_valid`=1 and `ciphertext` = state register.
  - On `out_valid & out_ready` the FSM returns to IDLE.
- Round counter is 4 bits and never exceeds Nr. There is no wrap-around.
- GF(2^8) arithmetic uses the reduction polynomial 0x11B. xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- `round_keys` is not latched. It must remain stable from the accept edge until the FSM leaves ROUND. If it changes during that window, the ciphertext is undefined and is not checked.
- `in_valid` while busy is ignored; no accept occurs because `in_ready`=0.

## Timing
- Reset values:
  - FSM = IDLE, round = 0.
  - `in_ready`=1 from the first cycle after reset.
  - `out_valid`=0, `busy`=0, `ciphertext`=0.
- Reset mid-operation:
  - The next edge forces IDLE and clears the outputs.
  - The in-flight block is discarded and never appears on the output.
- Latency:
  - `out_valid` rises exactly Nr cycles after the accepting edge: 10 for AES-128, 12 for AES-192, 14 for AES-256.
- Throughput:
  - One block per Nr+2 cycles when `out_ready` is held high: accept edge, Nr round edges, output edge.
  - `in_ready` returns to 1 the cycle after the output handshake.
- Output holding:
  - `ciphertext` and `out_valid` are held stable while `out_ready`=0, with no timeout.
  - If `out_ready` is already high when DONE is entered, the handshake completes on the first DONE cycle.
- All outputs are registered or decoded from the FSM only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `aes_pkg` holds:
  - FSM state encodings.
  - `NB`=4 and the block width 128.
  - xtime and mix-column helper functions.
  - The round-key slice helper.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box as a 256-entry case table, instantiated 16 times.
- ShiftRows, MixColumns and AddRoundKey are inline combinational logic in `aes_cipher_iter`.

## Test plan
- AES-128 FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c through `keyExpansion`, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32, `out_valid` exactly 10 cycles after accept.
- AES-192 and AES-256 with plaintext 00112233445566778899aabbccddeeff:
  - Key 000102…17 (Nk=6) gives dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
  - Key 000102…1f (Nk=8) gives 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure:
  - Stimulus: AES-128 key 000102…0f with the same plaintext; hold `out_ready`=0 for 5 cycles in DONE.
  - Required: ciphertext stays 69c4e0d86a7b0430d8cdb78070b4c55a, `in_ready` stays 0, and `in_valid` pulses are ignored.
- Back-to-back blocks:
  - Stimulus: `out_ready`=1 and `in_valid` held high with the App. B and App. C.1 blocks.
  - Required: both ciphertexts are correct, accepts are 12 cycles apart, and `in_ready` is low during processing.
- Reset at round 5:
  - Stimulus: assert `rst` for 1 cycle while in round 5.
  - Required: next cycle shows `out_valid`=0, `busy`=0, `in_ready`=1, `ciphertext`=0. A fresh block then produces correct output with no residue of the aborted block.
